l2_response_receiver: RTL and testbench



---
 rtl/l2_response_receiver_pkg.sv | 38 +++
 rtl/l2_response_fifo.sv | 50 +++++
 rtl/l2_response_receiver.sv | 146 ++++++++++++++
 tb/tb_l2_response_receiver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_response_receiver_pkg.sv
// Shared L2 response bus definitions: op codes, unit codes and the decoded entry layout.
// Imported by l2_response_fifo users and l2_response_receiver.
package l2_response_receiver_pkg;

   localparam int NUM_CORES        = 2;
   localparam int CORE_INDEX_WIDTH = 1;
   localparam int ADDR_WIDTH       = 26;
   localparam int LINE_WIDTH       = 512;

   localparam logic [1:0] L2RSP_LOAD_ACK    = 2'd0;
   localparam logic [1:0] L2RSP_STORE_ACK   = 2'd1;
   localparam logic [1:0] L2RSP_DINVALIDATE = 2'd2;
   localparam logic [1:0] L2RSP_IINVALIDATE = 2'd3;

   localparam logic [1:0] UNIT_ICACHE = 2'd0;
   localparam logic [1:0] UNIT_DCACHE = 2'd1;
   localparam logic [1:0] UNIT_STBUF  = 2'd2;

   // One queued packet after decode; the action bits are exactly the strobes it fires.
   typedef struct packed {
      logic                  icache_fill;
      logic                  icache_inval;
      logic                  dcache_fill;
      logic                  dcache_update;
      logic                  dcache_inval;
      logic                  store_ack;
      logic                  load_wake;
      logic                  wake_unit;
      logic [1:0]            strand;
      logic                  status;
      logic [ADDR_WIDTH-1:0] address;
      logic [1:0]            way;
      logic [LINE_WIDTH-1:0] data;
   } rsp_entry_t;

   localparam int ENTRY_WIDTH = $bits(rsp_entry_t);

endpackage

// File: rtl/l2_response_fifo.sv
// Generic-width synchronous FIFO with occupancy count and full/empty flags.
// An enqueue into a full FIFO is taken only when a dequeue happens in the same cycle.
module l2_response_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enq,
   input  logic                     deq,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_enq;
   logic             do_deq;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_deq  = deq & ~empty;
   assign do_enq  = enq & (~full | do_deq);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_deq) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_enq) - CNT_W'(do_deq);
      end
   end

   // Storage is left unreset; consumers qualify the head with empty.
   always_ff @(posedge clk) begin
      if (do_enq) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/l2_response_receiver.sv
// Core-side L2 response receiver: decodes relevant packets, queues them in order and dispatches them.
// Optional macro L2RSP_OVERFLOW_CHECK_EN builds a sticky overflow_err flag for dropped packets.
module l2_response_receiver
   import l2_response_receiver_pkg::*;
#(
   parameter int CORE_ID    = 0,
   parameter int FIFO_DEPTH = 4,
   parameter int SET_BITS   = 6
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          l2rsp_valid,
   input  logic                          l2rsp_status,
   input  logic [CORE_INDEX_WIDTH-1:0]   l2rsp_core,
   input  logic [1:0]                    l2rsp_unit,
   input  logic [1:0]                    l2rsp_strand,
   input  logic [1:0]                    l2rsp_op,
   input  logic [NUM_CORES-1:0]          l2rsp_update,
   input  logic [NUM_CORES*2-1:0]        l2rsp_way,
   input  logic [ADDR_WIDTH-1:0]         l2rsp_address,
   input  logic [LINE_WIDTH-1:0]         l2rsp_data,
   input  logic                          dcache_wr_ready,
   output logic [SET_BITS-1:0]           rsp_set,
   output logic [ADDR_WIDTH-SET_BITS-1:0] rsp_tag,
   output logic [1:0]                    rsp_way,
   output logic [LINE_WIDTH-1:0]         rsp_data,
   output logic                          icache_fill,
   output logic                          icache_inval,
   output logic                          dcache_fill,
   output logic                          dcache_update,
   output logic                          dcache_inval,
   output logic                          store_ack_valid,
   output logic [1:0]                    store_ack_strand,
   output logic                          store_ack_status,
   output logic                          load_wake_valid,
   output logic                          load_wake_unit,
   output logic [1:0]                    load_wake_strand,
   output logic                          overflow_err
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   rsp_entry_t       decoded;
   rsp_entry_t       head;
   logic             mine;
   logic             upd;
   logic             has_action;
   logic             accept;
   logic             dequeue;
   logic             head_valid;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   assign mine = (l2rsp_core == CORE_INDEX_WIDTH'(CORE_ID));
   assign upd  = l2rsp_update[CORE_ID];

   always_comb begin
      decoded         = '0;
      decoded.strand  = l2rsp_strand;
      decoded.status  = l2rsp_status;
      decoded.address = l2rsp_address;
      decoded.way     = l2rsp_way[CORE_ID*2 +: 2];
      decoded.data    = l2rsp_data;
      case (l2rsp_op)
         L2RSP_LOAD_ACK: begin
            if (mine && l2rsp_unit == UNIT_ICACHE) begin
               decoded.icache_fill = 1'b1;
               decoded.load_wake   = 1'b1;
            end else if (mine && l2rsp_unit == UNIT_DCACHE) begin
               decoded.dcache_fill = 1'b1;
               decoded.load_wake   = 1'b1;
               decoded.wake_unit   = 1'b1;
            end
         end
         L2RSP_STORE_ACK: begin
            decoded.dcache_update = upd;
            decoded.store_ack     = mine;
         end
         L2RSP_DINVALIDATE: begin
            decoded.dcache_inval = upd;
            decoded.store_ack    = mine;
            decoded.status       = 1'b1;
         end
         default: begin
            decoded.icache_inval = 1'b1;
            decoded.store_ack    = mine;
            decoded.status       = 1'b1;
         end
      endcase
   end

   assign has_action = decoded.icache_fill | decoded.icache_inval | decoded.dcache_fill |
                       decoded.dcache_update | decoded.dcache_inval | decoded.store_ack;
   assign accept     = l2rsp_valid & has_action & (~fifo_full | dequeue);

   l2_response_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .enq     (accept),
      .deq     (dequeue),
      .wr_data (decoded),
      .rd_data (head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Entries carrying an array write wait for the dcache port; everything else leaves immediately.
   assign head_valid = ~fifo_empty;
   assign dequeue    = head_valid & (~(head.dcache_fill | head.dcache_update) | dcache_wr_ready);

   assign icache_fill      = dequeue & head.icache_fill;
   assign icache_inval     = dequeue & head.icache_inval;
   assign dcache_fill      = dequeue & head.dcache_fill;
   assign dcache_update    = dequeue & head.dcache_update;
   assign dcache_inval     = dequeue & head.dcache_inval;
   assign store_ack_valid  = dequeue & head.store_ack;
   assign store_ack_strand = dequeue ? head.strand : 2'b00;
   assign store_ack_status = dequeue & head.status;
   assign load_wake_valid  = dequeue & head.load_wake;
   assign load_wake_unit   = dequeue & head.wake_unit;
   assign load_wake_strand = dequeue ? head.strand : 2'b00;

   assign rsp_set  = head_valid ? head.address[SET_BITS-1:0] : '0;
   assign rsp_tag  = head_valid ? head.address[ADDR_WIDTH-1:SET_BITS] : '0;
   assign rsp_way  = head_valid ? head.way : 2'b00;
   assign rsp_data = head_valid ? head.data : '0;

`ifdef L2RSP_OVERFLOW_CHECK_EN
   logic drop;
   assign drop = l2rsp_valid & has_action & (fifo_count == CNT_W'(FIFO_DEPTH)) & ~dequeue;

   // Sticky until reset so software can see that a response was ever lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     overflow_err <= 1'b0;
      else if (drop) overflow_err <= 1'b1;
   end
`else
   assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_l2_response_receiver.sv
// Directed self-checking bench for l2_response_receiver (CORE_ID=0, FIFO_DEPTH=4, SET_BITS=6).
// Honours L2RSP_OVERFLOW_CHECK_EN when choosing the expected overflow_err value.
module tb_l2_response_receiver;
   import l2_response_receiver_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         l2rsp_valid;
   logic         l2rsp_status;
   logic [0:0]   l2rsp_core;
   logic [1:0]   l2rsp_unit;
   logic [1:0]   l2rsp_strand;
   logic [1:0]   l2rsp_op;
   logic [1:0]   l2rsp_update;
   logic [3:0]   l2rsp_way;
   logic [25:0]  l2rsp_address;
   logic [511:0] l2rsp_data;
   logic         dcache_wr_ready;
   logic [5:0]   rsp_set;
   logic [19:0]  rsp_tag;
   logic [1:0]   rsp_way;
   logic [511:0] rsp_data;
   logic         icache_fill, icache_inval, dcache_fill, dcache_update, dcache_inval;
   logic         store_ack_valid, store_ack_status, load_wake_valid, load_wake_unit;
   logic [1:0]   store_ack_strand, load_wake_strand;
   logic         overflow_err;
   logic [6:0]   strobes;

   int total = 0;
   int bad   = 0;

`ifdef L2RSP_OVERFLOW_CHECK_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif

   always #5 clk = ~clk;

   assign strobes = {icache_fill, icache_inval, dcache_fill, dcache_update,
                     dcache_inval, store_ack_valid, load_wake_valid};

   l2_response_receiver #(.CORE_ID(0), .FIFO_DEPTH(4), .SET_BITS(6)) dut (
      .clk(clk), .reset(reset), .l2rsp_valid(l2rsp_valid), .l2rsp_status(l2rsp_status),
      .l2rsp_core(l2rsp_core), .l2rsp_unit(l2rsp_unit), .l2rsp_strand(l2rsp_strand),
      .l2rsp_op(l2rsp_op), .l2rsp_update(l2rsp_update), .l2rsp_way(l2rsp_way),
      .l2rsp_address(l2rsp_address), .l2rsp_data(l2rsp_data), .dcache_wr_ready(dcache_wr_ready),
      .rsp_set(rsp_set), .rsp_tag(rsp_tag), .rsp_way(rsp_way), .rsp_data(rsp_data),
      .icache_fill(icache_fill), .icache_inval(icache_inval), .dcache_fill(dcache_fill),
      .dcache_update(dcache_update), .dcache_inval(dcache_inval),
      .store_ack_valid(store_ack_valid), .store_ack_strand(store_ack_strand),
      .store_ack_status(store_ack_status), .load_wake_valid(load_wake_valid),
      .load_wake_unit(load_wake_unit), .load_wake_strand(load_wake_strand),
      .overflow_err(overflow_err)
   );

   task automatic send(input logic [1:0] op, input logic core, input logic [1:0] unit,
                       input logic [1:0] strand, input logic [1:0] update, input logic [3:0] way,
                       input logic [25:0] addr, input logic status);
      l2rsp_valid   = 1'b1;
      l2rsp_op      = op;
      l2rsp_core    = core;
      l2rsp_unit    = unit;
      l2rsp_strand  = strand;
      l2rsp_update  = update;
      l2rsp_way     = way;
      l2rsp_address = addr;
      l2rsp_status  = status;
      l2rsp_data    = {16{6'b0, addr}};
   endtask

   task automatic idle();
      l2rsp_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      l2rsp_op = 2'd0; l2rsp_core = 1'b0; l2rsp_unit = 2'd0; l2rsp_strand = 2'd0;
      l2rsp_update = 2'b00; l2rsp_way = 4'h0; l2rsp_address = '0; l2rsp_status = 1'b0;
      l2rsp_data = '0; dcache_wr_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (strobes !== 7'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=%b", strobes, 7'b0); end
      total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow_err); end
      total++; if (rsp_tag !== 20'h0) begin bad++; $display("FAIL reset_tag got=%h exp=0", rsp_tag); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_dcache_fill();
      dcache_wr_ready = 1'b1;
      send(L2RSP_LOAD_ACK, 1'b0, UNIT_DCACHE, 2'd2, 2'b01, 4'b1001, 26'h12345C0, 1'b0);
      step();
      idle();
      total++; if (strobes !== 7'b0010001) begin bad++; $display("FAIL fill_strobes got=%b exp=%b", strobes, 7'b0010001); end
      total++; if (rsp_set !== 6'h00) begin bad++; $display("FAIL fill_set got=%h exp=00", rsp_set); end
      total++; if (rsp_tag !== 20'h48D17) begin bad++; $display("FAIL fill_tag got=%h exp=48d17", rsp_tag); end
      total++; if (rsp_way !== 2'd1) begin bad++; $display("FAIL fill_way got=%0d exp=1", rsp_way); end
      total++; if (load_wake_unit !== 1'b1 || load_wake_strand !== 2'd2) begin
         bad++; $display("FAIL fill_wake got unit=%b strand=%0d exp unit=1 strand=2", load_wake_unit, load_wake_strand);
      end
      total++; if (rsp_data !== {16{32'h012345C0}}) begin bad++; $display("FAIL fill_data got=%h exp=%h", rsp_data[31:0], 32'h012345C0); end
      step();
      total++; if (strobes !== 7'b0) begin bad++; $display("FAIL fill_after got=%b exp=0", strobes); end
   endtask

   task automatic test_store_ack();
      send(L2RSP_STORE_ACK, 1'b1, UNIT_STBUF, 2'd1, 2'b01, 4'h0, 26'h100, 1'b1);
      step(); idle();
      total++; if (strobes !== 7'b0001000) begin bad++; $display("FAIL st_other_core got=%b exp=%b", strobes, 7'b0001000); end
      step();
      send(L2RSP_STORE_ACK, 1'b0, UNIT_STBUF, 2'd3, 2'b01, 4'h0, 26'h100, 1'b0);
      step(); idle();
      total++; if (strobes !== 7'b0001010) begin bad++; $display("FAIL st_mine got=%b exp=%b", strobes, 7'b0001010); end
      total++; if (store_ack_strand !== 2'd3 || store_ack_status !== 1'b0) begin
         bad++; $display("FAIL st_mine_ack got strand=%0d status=%b exp strand=3 status=0", store_ack_strand, store_ack_status);
      end
      step();
      send(L2RSP_STORE_ACK, 1'b0, UNIT_STBUF, 2'd0, 2'b10, 4'h0, 26'h100, 1'b1);
      step(); idle();
      total++; if (strobes !== 7'b0000010 || store_ack_status !== 1'b1) begin
         bad++; $display("FAIL st_noupd got=%b status=%b exp=%b status=1", strobes, store_ack_status, 7'b0000010);
      end
      step();
   endtask

   task automatic test_invalidate();
      send(L2RSP_DINVALIDATE, 1'b0, UNIT_STBUF, 2'd1, 2'b01, 4'h0, 26'h240, 1'b0);
      step(); idle();
      total++; if (strobes !== 7'b0000110 || store_ack_status !== 1'b1) begin
         bad++; $display("FAIL dinv got=%b status=%b exp=%b status=1", strobes, store_ack_status, 7'b0000110);
      end
      step();
      send(L2RSP_IINVALIDATE, 1'b1, UNIT_STBUF, 2'd1, 2'b00, 4'h0, 26'h240, 1'b0);
      step(); idle();
      total++; if (strobes !== 7'b0100000) begin bad++; $display("FAIL iinv got=%b exp=%b", strobes, 7'b0100000); end
      step();
      send(L2RSP_LOAD_ACK, 1'b0, UNIT_ICACHE, 2'd1, 2'b00, 4'b0010, 26'h3C5, 1'b0);
      step(); idle();
      total++; if (strobes !== 7'b1000001 || load_wake_unit !== 1'b0 || load_wake_strand !== 2'd1) begin
         bad++; $display("FAIL ifill got=%b unit=%b strand=%0d exp=%b unit=0 strand=1",
                         strobes, load_wake_unit, load_wake_strand, 7'b1000001);
      end
      total++; if (rsp_set !== 6'h05 || rsp_tag !== 20'h0000F || rsp_way !== 2'd2) begin
         bad++; $display("FAIL ifill_fields got set=%h tag=%h way=%0d exp set=05 tag=0000f way=2", rsp_set, rsp_tag, rsp_way);
      end
      step();
   endtask

   task automatic test_discard();
      send(L2RSP_LOAD_ACK, 1'b1, UNIT_DCACHE, 2'd0, 2'b00, 4'h0, 26'h1000, 1'b0);
      step(); idle();
      total++; if (strobes !== 7'b0) begin bad++; $display("FAIL discard_other got=%b exp=0", strobes); end
      send(L2RSP_LOAD_ACK, 1'b0, UNIT_STBUF, 2'd0, 2'b01, 4'h0, 26'h1000, 1'b0);
      step(); idle();
      total++; if (strobes !== 7'b0 || rsp_tag !== 20'h0) begin
         bad++; $display("FAIL discard_unit2 got=%b tag=%h exp=0 tag=0", strobes, rsp_tag);
      end
   endtask

   task automatic test_full_accept();
      dcache_wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(L2RSP_LOAD_ACK, 1'b0, UNIT_DCACHE, 2'(i), 2'b00, 4'h1, 26'((8 + i) * 64 + i), 1'b0);
         step();
      end
      idle();
      total++; if (strobes !== 7'b0 || dut.u_fifo.full !== 1'b1) begin
         bad++; $display("FAIL fa_fill got=%b full=%b exp=0 full=1", strobes, dut.u_fifo.full);
      end
      dcache_wr_ready = 1'b1;
      send(L2RSP_LOAD_ACK, 1'b0, UNIT_DCACHE, 2'd0, 2'b00, 4'h1, 26'(12 * 64 + 4), 1'b0);
      #1;
      total++; if (dcache_fill !== 1'b1 || rsp_tag !== 20'd8) begin
         bad++; $display("FAIL fa_head got fill=%b tag=%0d exp fill=1 tag=8", dcache_fill, rsp_tag);
      end
      for (int t = 9; t <= 12; t++) begin
         @(posedge clk);
         #1;
         idle();
         total++; if (dcache_fill !== 1'b1 || rsp_tag !== 20'(t)) begin
            bad++; $display("FAIL fa_drain got fill=%b tag=%0d exp fill=1 tag=%0d", dcache_fill, rsp_tag, t);
         end
      end
      step();
      total++; if (strobes !== 7'b0 || overflow_err !== 1'b0) begin
         bad++; $display("FAIL fa_end got=%b ovf=%b exp=0 ovf=0", strobes, overflow_err);
      end
   endtask

   task automatic test_overflow();
      dcache_wr_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         send(L2RSP_LOAD_ACK, 1'b0, UNIT_DCACHE, 2'(i), 2'b00, 4'h2, 26'(i * 64 + i), 1'b0);
         step();
         total++; if (strobes !== 7'b0) begin bad++; $display("FAIL ov_hold got=%b exp=0", strobes); end
      end
      total++; if (dut.u_fifo.full !== 1'b1) begin bad++; $display("FAIL ov_full got=%b exp=1", dut.u_fifo.full); end
      send(L2RSP_LOAD_ACK, 1'b0, UNIT_DCACHE, 2'd0, 2'b00, 4'h2, 26'(5 * 64 + 5), 1'b0);
      step(); idle();
      total++; if (overflow_err !== EXP_OVF) begin bad++; $display("FAIL ov_flag got=%b exp=%b", overflow_err, EXP_OVF); end
      dcache_wr_ready = 1'b1;
      #1;
      total++; if (dcache_fill !== 1'b1 || rsp_tag !== 20'd1 || rsp_set !== 6'd1) begin
         bad++; $display("FAIL ov_drain got fill=%b tag=%0d set=%0d exp fill=1 tag=1 set=1", dcache_fill, rsp_tag, rsp_set);
      end
      for (int t = 2; t <= 4; t++) begin
         @(posedge clk);
         #1;
         total++; if (dcache_fill !== 1'b1 || rsp_tag !== 20'(t) || load_wake_strand !== 2'(t)) begin
            bad++; $display("FAIL ov_drain got fill=%b tag=%0d strand=%0d exp fill=1 tag=%0d strand=%0d",
                            dcache_fill, rsp_tag, load_wake_strand, t, t & 3);
         end
      end
      step();
      total++; if (strobes !== 7'b0 || overflow_err !== EXP_OVF) begin
         bad++; $display("FAIL ov_end got=%b ovf=%b exp=0 ovf=%b", strobes, overflow_err, EXP_OVF);
      end
   endtask

   task automatic test_reset_mid();
      dcache_wr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(L2RSP_LOAD_ACK, 1'b0, UNIT_DCACHE, 2'd1, 2'b00, 4'h3, 26'(20 * 64 + i), 1'b0);
         step();
      end
      idle();
      reset = 1'b1;
      dcache_wr_ready = 1'b1;
      #1;
      total++; if (strobes !== 7'b0 || rsp_tag !== 20'h0 || overflow_err !== 1'b0) begin
         bad++; $display("FAIL rst_mid got=%b tag=%h ovf=%b exp=0 tag=0 ovf=0", strobes, rsp_tag, overflow_err);
      end
      step();
      reset = 1'b0;
      step();
      total++; if (strobes !== 7'b0 || rsp_tag !== 20'h0) begin
         bad++; $display("FAIL rst_stale got=%b tag=%h exp=0 tag=0", strobes, rsp_tag);
      end
      send(L2RSP_LOAD_ACK, 1'b0, UNIT_DCACHE, 2'd3, 2'b00, 4'h3, 26'h3FFFFFF, 1'b0);
      step(); idle();
      total++; if (dcache_fill !== 1'b1 || rsp_tag !== 20'hFFFFF || rsp_set !== 6'h3F || rsp_way !== 2'd3) begin
         bad++; $display("FAIL rst_after got fill=%b tag=%h set=%h way=%0d exp fill=1 tag=fffff set=3f way=3",
                         dcache_fill, rsp_tag, rsp_set, rsp_way);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_dcache_fill();
      test_store_ack();
      test_invalidate();
      test_discard();
      test_full_accept();
      test_overflow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
